// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - opcode/funct constants, op-id, imm-type and mem-size types for the decode stage
package idu_pkg;

   // major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0] OPC_OPIMM    = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
   localparam logic [6:0] OPC_OPIMM32  = 7'b001_1011;
   localparam logic [6:0] OPC_STORE    = 7'b010_0011;
   localparam logic [6:0] OPC_OP       = 7'b011_0011;
   localparam logic [6:0] OPC_LUI      = 7'b011_0111;
   localparam logic [6:0] OPC_OP32     = 7'b011_1011;
   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

   // funct7 patterns
   localparam logic [6:0] F7_BASE      = 7'b000_0000;
   localparam logic [6:0] F7_ALT       = 7'b010_0000;

   // ebreak is matched on the whole word
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [5:0] {
      OP_ILLEGAL = 6'h00,
      OP_ADDI    = 6'h01,
      OP_EBREAK  = 6'h02,
      OP_AUIPC   = 6'h03,
      OP_LUI     = 6'h04,
      OP_JAL     = 6'h05,
      OP_JALR    = 6'h06,
      OP_SD      = 6'h07,
      OP_SW      = 6'h08,
      OP_SH      = 6'h09,
      OP_SB      = 6'h0a,
      OP_ADDW    = 6'h0c,
      OP_SUB     = 6'h0e,
      OP_ADD     = 6'h0f,
      OP_ADDIW   = 6'h10,
      OP_SLTIU   = 6'h20,
      OP_LW      = 6'h21,
      OP_LD      = 6'h22,
      OP_LB      = 6'h23,
      OP_LH      = 6'h24,
      OP_LBU     = 6'h25,
      OP_LHU     = 6'h26,
      OP_LWU     = 6'h27,
      OP_BEQ     = 6'h29,
      OP_BNE     = 6'h2a
   } op_id_e;

   typedef enum logic [6:0] {
      IMM_I = 7'h40,
      IMM_R = 7'h41,
      IMM_U = 7'h42,
      IMM_J = 7'h43,
      IMM_S = 7'h44,
      IMM_B = 7'h45
   } imm_type_e;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_e;

   // XLEN-independent part of a decoded instruction
   typedef struct packed {
      op_id_e    op_id;
      logic      reg_write;
      logic      src1_is_pc;
      logic      src2_is_imm;
      logic      mem_read;
      logic      mem_write;
      mem_size_e mem_size;
      logic      load_uns;
      logic      ebreak;
      logic      illegal;
   } ctrl_t;

   // Illegal falls into IMM_R so it shares the zero immediate and src2_is_imm=0.
   function automatic imm_type_e imm_type_of(input op_id_e op);
      imm_type_e t;
      case (op)
         OP_ADDI, OP_EBREAK, OP_JALR, OP_ADDIW, OP_SLTIU,
         OP_LW, OP_LD, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LWU: t = IMM_I;
         OP_AUIPC, OP_LUI:                                   t = IMM_U;
         OP_JAL:                                             t = IMM_J;
         OP_SD, OP_SW, OP_SH, OP_SB:                         t = IMM_S;
         OP_BEQ, OP_BNE:                                     t = IMM_B;
         default:                                            t = IMM_R;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/idu_decode.sv
// rtl/idu_decode.sv - combinational instruction decoder: raw inst to control, immediate and store mask
module idu_decode
   import idu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]       inst_i,
   output ctrl_t             ctrl_o,
   output logic [XLEN-1:0]   imm_o,
   output logic [XLEN/8-1:0] wmask_o
);

   localparam bit IS64 = (XLEN == 64);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   op_id_e     op;
   imm_type_e  imm_type;

   assign opcode   = inst_i[6:0];
   assign funct3   = inst_i[14:12];
   assign funct7   = inst_i[31:25];
   assign imm_type = imm_type_of(op);

   // masked opcode/funct3/funct7 match; RV64-only ops stay illegal on RV32
   always_comb begin
      op = OP_ILLEGAL;
      case (opcode)
         OPC_OPIMM: begin
            if (funct3 == 3'b000) op = OP_ADDI;
            else if (funct3 == 3'b011) op = OP_SLTIU;
         end
         OPC_OPIMM32: begin
            if (IS64 && funct3 == 3'b000) op = OP_ADDIW;
         end
         OPC_OP: begin
            if (funct3 == 3'b000 && funct7 == F7_BASE) op = OP_ADD;
            else if (funct3 == 3'b000 && funct7 == F7_ALT) op = OP_SUB;
         end
         OPC_OP32: begin
            if (IS64 && funct3 == 3'b000 && funct7 == F7_BASE) op = OP_ADDW;
         end
         OPC_LUI:   op = OP_LUI;
         OPC_AUIPC: op = OP_AUIPC;
         OPC_JAL:   op = OP_JAL;
         OPC_JALR: begin
            if (funct3 == 3'b000) op = OP_JALR;
         end
         OPC_BRANCH: begin
            if (funct3 == 3'b000) op = OP_BEQ;
            else if (funct3 == 3'b001) op = OP_BNE;
         end
         OPC_LOAD: begin
            case (funct3)
               3'b000:  op = OP_LB;
               3'b001:  op = OP_LH;
               3'b010:  op = OP_LW;
               3'b011:  op = IS64 ? OP_LD : OP_ILLEGAL;
               3'b100:  op = OP_LBU;
               3'b101:  op = OP_LHU;
               3'b110:  op = IS64 ? OP_LWU : OP_ILLEGAL;
               default: op = OP_ILLEGAL;
            endcase
         end
         OPC_STORE: begin
            case (funct3)
               3'b000:  op = OP_SB;
               3'b001:  op = OP_SH;
               3'b010:  op = OP_SW;
               3'b011:  op = IS64 ? OP_SD : OP_ILLEGAL;
               default: op = OP_ILLEGAL;
            endcase
         end
         OPC_SYSTEM: begin
            if (inst_i == INST_EBREAK) op = OP_EBREAK;
         end
         default: op = OP_ILLEGAL;
      endcase
   end

   // control bits derived from the matched op; illegal leaves everything at zero
   always_comb begin
      ctrl_o          = '0;
      ctrl_o.op_id    = op;
      ctrl_o.illegal  = (op == OP_ILLEGAL);
      ctrl_o.ebreak   = (op == OP_EBREAK);
      ctrl_o.src2_is_imm = (imm_type != IMM_R);
      ctrl_o.src1_is_pc  = (op == OP_AUIPC) || (op == OP_JAL) ||
                           (op == OP_BEQ) || (op == OP_BNE);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU: ctrl_o.mem_read = 1'b1;
         default: ctrl_o.mem_read = 1'b0;
      endcase
      ctrl_o.mem_write = (imm_type == IMM_S);
      ctrl_o.load_uns  = (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
      case (op)
         OP_LB, OP_LBU, OP_SB: ctrl_o.mem_size = MEM_B;
         OP_LH, OP_LHU, OP_SH: ctrl_o.mem_size = MEM_H;
         OP_LW, OP_LWU, OP_SW: ctrl_o.mem_size = MEM_W;
         OP_LD, OP_SD:         ctrl_o.mem_size = MEM_D;
         default:              ctrl_o.mem_size = MEM_B;
      endcase
      // writes to x0 are suppressed here so EXU never has to special-case rd
      ctrl_o.reg_write = !ctrl_o.illegal && !ctrl_o.ebreak && !ctrl_o.mem_write &&
                         (imm_type != IMM_B) && (inst_i[11:7] != 5'd0);
   end

   // immediate assembly; the sign bit is replicated to fill XLEN
   always_comb begin
      imm_o = '0;
      case (imm_type)
         IMM_I: imm_o = {{(XLEN-11){inst_i[31]}}, inst_i[30:20]};
         IMM_S: imm_o = {{(XLEN-11){inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
         IMM_B: imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
         IMM_U: imm_o = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'h000};
         IMM_J: imm_o = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

   // store byte mask: low 2^mem_size bytes enabled
   always_comb begin
      wmask_o = '0;
      for (int i = 0; i < XLEN/8; i++) begin
         wmask_o[i] = ctrl_o.mem_write && (i < (1 << ctrl_o.mem_size));
      end
   end

endmodule

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - handshaked decode stage: input FIFO with bypass feeding a registered decoded bundle
module idu_stage
   import idu_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_flush,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [XLEN-1:0]   io_in_pc,
   input  logic [31:0]       io_in_inst,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [XLEN-1:0]   io_out_pc,
   output logic [31:0]       io_out_inst,
   output logic [4:0]        io_out_rs1,
   output logic [4:0]        io_out_rs2,
   output logic [4:0]        io_out_rd,
   output logic [XLEN-1:0]   io_out_imm,
   output logic [5:0]        io_out_op_id,
   output logic              io_out_reg_write,
   output logic              io_out_src1_is_pc,
   output logic              io_out_src2_is_imm,
   output logic              io_out_mem_read,
   output logic              io_out_mem_write,
   output logic [1:0]        io_out_mem_size,
   output logic              io_out_load_uns,
   output logic [XLEN/8-1:0] io_out_wmask,
   output logic              io_out_ebreak,
   output logic              io_out_illegal
);

   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 0;
   localparam int IDX_W = (AW > 0) ? AW : 1;
   localparam int PTR_W = AW + 1;

   // FIFO storage and wrap-bit pointers
   logic [XLEN-1:0]  pc_mem_q   [FIFO_DEPTH];
   logic [31:0]      inst_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   // output register
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic [31:0]       out_inst_q, out_inst_d;
   logic [XLEN-1:0]   out_imm_q, out_imm_d;
   ctrl_t             out_ctrl_q, out_ctrl_d;
   logic [XLEN/8-1:0] out_wmask_q, out_wmask_d;

   logic              fifo_empty, fifo_full;
   logic              in_fire, out_load, enq, deq;
   logic              src_valid;
   logic [XLEN-1:0]   src_pc;
   logic [31:0]       src_inst;
   ctrl_t             dec_ctrl;
   logic [XLEN-1:0]   dec_imm;
   logic [XLEN/8-1:0] dec_wmask;

   if (AW == 0) begin : g_idx_single
      assign wr_idx = '0;
      assign rd_idx = '0;
   end else begin : g_idx_multi
      assign wr_idx = wr_ptr_q[IDX_W-1:0];
      assign rd_idx = rd_ptr_q[IDX_W-1:0];
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);

   assign io_in_ready = !fifo_full;
   assign in_fire     = io_in_valid && io_in_ready && !io_flush;
   assign out_load    = !out_valid_q || io_out_ready;

   // head of FIFO has priority; an empty FIFO lets the incoming pair straight through
   assign src_valid = !fifo_empty || in_fire;
   assign src_pc    = fifo_empty ? io_in_pc   : pc_mem_q[rd_idx];
   assign src_inst  = fifo_empty ? io_in_inst : inst_mem_q[rd_idx];

   assign deq = out_load && !fifo_empty && !io_flush;
   assign enq = in_fire && !(fifo_empty && out_load);

   idu_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .inst_i  (src_inst),
      .ctrl_o  (dec_ctrl),
      .imm_o   (dec_imm),
      .wmask_o (dec_wmask)
   );

   // next-state for pointers and output register; flush overrides everything
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      out_imm_d   = out_imm_q;
      out_ctrl_d  = out_ctrl_q;
      out_wmask_d = out_wmask_q;
      if (io_flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         out_valid_d = 1'b0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
         if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
         if (out_load) begin
            out_valid_d = src_valid;
            if (src_valid) begin
               out_pc_d    = src_pc;
               out_inst_d  = src_inst;
               out_imm_d   = dec_imm;
               out_ctrl_d  = dec_ctrl;
               out_wmask_d = dec_wmask;
            end
         end
      end
   end

   // FIFO payload writes; contents need no reset since pointers define validity
   always_ff @(posedge clock) begin
      if (enq) begin
         pc_mem_q[wr_idx]   <= io_in_pc;
         inst_mem_q[wr_idx] <= io_in_inst;
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_inst_q  <= '0;
         out_imm_q   <= '0;
         out_ctrl_q  <= '0;
         out_wmask_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
         out_imm_q   <= out_imm_d;
         out_ctrl_q  <= out_ctrl_d;
         out_wmask_q <= out_wmask_d;
      end
   end

   assign io_out_valid       = out_valid_q;
   assign io_out_pc          = out_pc_q;
   assign io_out_inst        = out_inst_q;
   assign io_out_rs1         = out_inst_q[19:15];
   assign io_out_rs2         = out_inst_q[24:20];
   assign io_out_rd          = out_inst_q[11:7];
   assign io_out_imm         = out_imm_q;
   assign io_out_op_id       = out_ctrl_q.op_id;
   assign io_out_reg_write   = out_ctrl_q.reg_write;
   assign io_out_src1_is_pc  = out_ctrl_q.src1_is_pc;
   assign io_out_src2_is_imm = out_ctrl_q.src2_is_imm;
   assign io_out_mem_read    = out_ctrl_q.mem_read;
   assign io_out_mem_write   = out_ctrl_q.mem_write;
   assign io_out_mem_size    = out_ctrl_q.mem_size;
   assign io_out_load_uns    = out_ctrl_q.load_uns;
   assign io_out_wmask       = out_wmask_q;
   assign io_out_ebreak      = out_ctrl_q.ebreak;
   assign io_out_illegal     = out_ctrl_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - scoreboard bench for idu_stage at XLEN=64 and XLEN=32
module tb_idu_stage;

   // flag vector layout: {rw, s1pc, s2imm, mr, mw, msz[1:0], luns, ebreak, illegal}
   localparam logic [9:0] F_RW   = 10'h200;
   localparam logic [9:0] F_S1PC = 10'h100;
   localparam logic [9:0] F_S2I  = 10'h080;
   localparam logic [9:0] F_MR   = 10'h040;
   localparam logic [9:0] F_MW   = 10'h020;
   localparam logic [9:0] F_SZ_H = 10'h008;
   localparam logic [9:0] F_SZ_W = 10'h010;
   localparam logic [9:0] F_SZ_D = 10'h018;
   localparam logic [9:0] F_LU   = 10'h004;
   localparam logic [9:0] F_EBK  = 10'h002;
   localparam logic [9:0] F_ILL  = 10'h001;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [5:0]  op;
      logic [63:0] imm;
      logic [9:0]  f;
      logic [7:0]  wm;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   // XLEN=64 instance signals
   logic        flush, in_valid, out_ready, in_ready, out_valid;
   logic [63:0] in_pc, out_pc, out_imm;
   logic [31:0] in_inst, out_inst;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [5:0]  out_op;
   logic        rw, s1pc, s2imm, mr, mw, luns, ebk, ill;
   logic [1:0]  msz;
   logic [7:0]  wmask;

   // XLEN=32 instance signals
   logic        flush32, in_valid32, out_ready32, in_ready32, out_valid32;
   logic [31:0] in_pc32, out_pc32, out_imm32;
   logic [31:0] in_inst32, out_inst32;
   logic [4:0]  out_rs1_32, out_rs2_32, out_rd_32;
   logic [5:0]  out_op32;
   logic        rw32, s1pc32, s2imm32, mr32, mw32, luns32, ebk32, ill32;
   logic [1:0]  msz32;
   logic [3:0]  wmask32;

   idu_stage #(.XLEN(64), .FIFO_DEPTH(2)) u_dut (
      .clock(clock), .reset(reset), .io_flush(flush),
      .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_pc(in_pc), .io_in_inst(in_inst),
      .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_pc(out_pc),
      .io_out_inst(out_inst), .io_out_rs1(out_rs1), .io_out_rs2(out_rs2), .io_out_rd(out_rd),
      .io_out_imm(out_imm), .io_out_op_id(out_op), .io_out_reg_write(rw),
      .io_out_src1_is_pc(s1pc), .io_out_src2_is_imm(s2imm), .io_out_mem_read(mr),
      .io_out_mem_write(mw), .io_out_mem_size(msz), .io_out_load_uns(luns),
      .io_out_wmask(wmask), .io_out_ebreak(ebk), .io_out_illegal(ill)
   );

   idu_stage #(.XLEN(32), .FIFO_DEPTH(2)) u_dut32 (
      .clock(clock), .reset(reset), .io_flush(flush32),
      .io_in_valid(in_valid32), .io_in_ready(in_ready32), .io_in_pc(in_pc32),
      .io_in_inst(in_inst32), .io_out_valid(out_valid32), .io_out_ready(out_ready32),
      .io_out_pc(out_pc32), .io_out_inst(out_inst32), .io_out_rs1(out_rs1_32),
      .io_out_rs2(out_rs2_32), .io_out_rd(out_rd_32), .io_out_imm(out_imm32),
      .io_out_op_id(out_op32), .io_out_reg_write(rw32), .io_out_src1_is_pc(s1pc32),
      .io_out_src2_is_imm(s2imm32), .io_out_mem_read(mr32), .io_out_mem_write(mw32),
      .io_out_mem_size(msz32), .io_out_load_uns(luns32), .io_out_wmask(wmask32),
      .io_out_ebreak(ebk32), .io_out_illegal(ill32)
   );

   exp_t sb64[$];
   exp_t sb32[$];
   exp_t e64, a64, e32, a32;
   logic [63:0] pc64 = 64'h0000_0001_8000_0000;
   logic [31:0] pc32 = 32'h8000_0000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_bundle(input string tag, input exp_t e, input exp_t a,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      chk({tag, " pc"},    a.pc,   e.pc);
      chk({tag, " inst"},  a.inst, e.inst);
      chk({tag, " op_id"}, {58'd0, a.op}, {58'd0, e.op});
      chk({tag, " imm"},   a.imm,  e.imm);
      chk({tag, " ctrl"},  {54'd0, a.f}, {54'd0, e.f});
      chk({tag, " wmask"}, {56'd0, a.wm}, {56'd0, e.wm});
      chk({tag, " regs"},  {49'd0, rs1, rs2, rd},
          {49'd0, e.inst[19:15], e.inst[24:20], e.inst[11:7]});
   endtask

   function automatic exp_t mk(input logic [31:0] inst, input logic [5:0] op,
                               input logic [63:0] imm, input logic [9:0] f, input logic [7:0] wm);
      exp_t e;
      e.pc = '0; e.inst = inst; e.op = op; e.imm = imm; e.f = f; e.wm = wm;
      return e;
   endfunction

   // monitor for the XLEN=64 instance
   always @(negedge clock) begin
      if (reset && !flush && out_valid && out_ready) begin
         if (sb64.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out64: got inst 0x%0h expected no output", out_inst);
         end else begin
            e64 = sb64.pop_front();
            a64.pc = out_pc; a64.inst = out_inst; a64.op = out_op; a64.imm = out_imm;
            a64.f = {rw, s1pc, s2imm, mr, mw, msz, luns, ebk, ill}; a64.wm = wmask;
            cmp_bundle($sformatf("x64[%08h]", e64.inst), e64, a64, out_rs1, out_rs2, out_rd);
         end
         delivered++;
      end
   end

   // monitor for the XLEN=32 instance
   always @(negedge clock) begin
      if (reset && !flush32 && out_valid32 && out_ready32) begin
         if (sb32.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out32: got inst 0x%0h expected no output", out_inst32);
         end else begin
            e32 = sb32.pop_front();
            a32.pc = {32'd0, out_pc32}; a32.inst = out_inst32; a32.op = out_op32;
            a32.imm = {32'd0, out_imm32};
            a32.f = {rw32, s1pc32, s2imm32, mr32, mw32, msz32, luns32, ebk32, ill32};
            a32.wm = {4'd0, wmask32};
            cmp_bundle($sformatf("x32[%08h]", e32.inst), e32, a32, out_rs1_32, out_rs2_32,
                       out_rd_32);
         end
      end
   end

   task automatic send64(input exp_t e);
      int waited = 0;
      in_valid = 1'b1; in_pc = pc64; in_inst = e.inst; e.pc = pc64;
      forever begin
         @(negedge clock);
         if (in_ready) begin
            sb64.push_back(e);
            @(posedge clock); #1;
            break;
         end
         @(posedge clock); #1;
         waited++;
         if (waited > 50) begin
            checks++; errors++;
            $display("FAIL send64_timeout: got in_ready 0 expected 1 within 50 cycles");
            break;
         end
      end
      in_valid = 1'b0;
      pc64 = pc64 + 64'd4;
   endtask

   task automatic send32(input exp_t e);
      int waited = 0;
      in_valid32 = 1'b1; in_pc32 = pc32; in_inst32 = e.inst; e.pc = {32'd0, pc32};
      forever begin
         @(negedge clock);
         if (in_ready32) begin
            sb32.push_back(e);
            @(posedge clock); #1;
            break;
         end
         @(posedge clock); #1;
         waited++;
         if (waited > 50) begin
            checks++; errors++;
            $display("FAIL send32_timeout: got in_ready 0 expected 1 within 50 cycles");
            break;
         end
      end
      in_valid32 = 1'b0;
      pc32 = pc32 + 32'd4;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && (sb64.size() != 0 || sb32.size() != 0); i++) @(posedge clock);
      #1;
      chk({name, " pending"}, 64'(sb64.size() + sb32.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1);
   end

   initial begin
      int d0;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_inst = '0;
      flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1; in_pc32 = '0; in_inst32 = '0;
      repeat (2) @(posedge clock); #1;

      // reset state
      chk("rst in_ready",  {63'd0, in_ready}, 64'd1);
      chk("rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst fields",    {out_imm ^ out_pc, out_inst, 26'd0, out_op}, '0);
      chk("rst ctrl",      {54'd0, rw, s1pc, s2imm, mr, mw, msz, luns, ebk, ill}, 64'd0);
      chk("rst x32",       {62'd0, in_ready32, out_valid32}, 64'd2);
      reset = 1'b1;
      @(posedge clock); #1;

      // addi x1,x0,-1 with one-cycle latency
      send64(mk(32'hfff00093, 6'h01, 64'hFFFF_FFFF_FFFF_FFFF, F_RW | F_S2I, 8'h00));
      chk("t1 latency", {63'd0, out_valid}, 64'd1);
      drain("t1");

      // backpressure: DEPTH=2 plus output register holds three
      out_ready = 1'b0;
      send64(mk(32'h123452b7, 6'h04, 64'h0000_0000_1234_5000, F_RW | F_S2I, 8'h00));
      send64(mk(32'h002081b3, 6'h0f, 64'd0, F_RW, 8'h00));
      send64(mk(32'h402081b3, 6'h0e, 64'd0, F_RW, 8'h00));
      chk("t2 full in_ready", {63'd0, in_ready}, 64'd0);
      chk("t2 held out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      d0 = delivered;
      repeat (3) @(posedge clock); #1;
      chk("t2 one per cycle", 64'(delivered - d0), 64'd3);
      drain("t2");

      // stores, illegal, ebreak and assorted decodes streamed back to back
      send64(mk(32'h00208423, 6'h0a, 64'd8, F_S2I | F_MW, 8'h01));
      send64(mk(32'h00209423, 6'h09, 64'd8, F_S2I | F_MW | F_SZ_H, 8'h03));
      send64(mk(32'h0020a423, 6'h08, 64'd8, F_S2I | F_MW | F_SZ_W, 8'h0F));
      send64(mk(32'h0020b423, 6'h07, 64'd8, F_S2I | F_MW | F_SZ_D, 8'hFF));
      send64(mk(32'hffffffff, 6'h00, 64'd0, F_ILL, 8'h00));
      send64(mk(32'h00100073, 6'h02, 64'd1, F_S2I | F_EBK, 8'h00));
      send64(mk(32'hfff0c283, 6'h25, 64'hFFFF_FFFF_FFFF_FFFF, F_RW | F_S2I | F_MR | F_LU, 8'h00));
      send64(mk(32'h008000ef, 6'h05, 64'd8, F_RW | F_S1PC | F_S2I, 8'h00));
      send64(mk(32'h00000013, 6'h01, 64'd0, F_S2I, 8'h00));
      send64(mk(32'h0000b083, 6'h22, 64'd0, F_RW | F_S2I | F_MR | F_SZ_D, 8'h00));
      send64(mk(32'h800000b7, 6'h04, 64'hFFFF_FFFF_8000_0000, F_RW | F_S2I, 8'h00));
      send64(mk(32'h002081bb, 6'h0c, 64'd0, F_RW, 8'h00));
      drain("t3");

      // flush with a full FIFO and input offered in the flush cycle
      out_ready = 1'b0;
      send64(mk(32'h00500293, 6'h01, 64'd5, F_RW | F_S2I, 8'h00));
      send64(mk(32'h002081b3, 6'h0f, 64'd0, F_RW, 8'h00));
      send64(mk(32'h402081b3, 6'h0e, 64'd0, F_RW, 8'h00));
      chk("t5 full before flush", {63'd0, in_ready}, 64'd0);
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00100073; in_pc = 64'hDEAD; out_ready = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      sb64.delete();
      chk("t5 out_valid after flush", {63'd0, out_valid}, 64'd0);
      chk("t5 in_ready after flush", {63'd0, in_ready}, 64'd1);
      repeat (3) @(posedge clock); #1;
      send64(mk(32'h00500293, 6'h01, 64'd5, F_RW | F_S2I, 8'h00));
      chk("t5 bypass after flush", {63'd0, out_valid}, 64'd1);
      drain("t5");

      // XLEN=32 instance
      send32(mk(32'h0000b083, 6'h00, 64'd0, F_ILL, 8'h00));
      send32(mk(32'hfe001ee3, 6'h2a, 64'h0000_0000_FFFF_FFFC, F_S1PC | F_S2I, 8'h00));
      send32(mk(32'h0020a423, 6'h08, 64'd8, F_S2I | F_MW | F_SZ_W, 8'h0F));
      send32(mk(32'hfff00093, 6'h01, 64'h0000_0000_FFFF_FFFF, F_RW | F_S2I, 8'h00));
      send32(mk(32'h002081bb, 6'h00, 64'd0, F_ILL, 8'h00));
      drain("t6");

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send64(mk(32'h002081b3, 6'h0f, 64'd0, F_RW, 8'h00));
      send64(mk(32'h402081b3, 6'h0e, 64'd0, F_RW, 8'h00));
      reset = 1'b0;
      #2;
      chk("t7 reset out_valid", {63'd0, out_valid}, 64'd0);
      chk("t7 reset in_ready",  {63'd0, in_ready}, 64'd1);
      chk("t7 reset op_id",     {58'd0, out_op}, 64'd0);
      sb64.delete();
      @(posedge clock); #1;
      reset = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clock); #1;
      chk("t7 idle after reset", {63'd0, out_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
